hamming_enc_sequencer: RTL and testbench
========================================

# hamming_enc_sequencer

Hardware sequencer that runs the program-1 Hamming(16,11) encode job against the shared data memory. On a `req` pulse it requests the memory bus, reads NUM_MSG packed 11-bit messages from the source area, and computes the four Hamming parity bits plus overall parity. It writes each 16-bit codeword to the destination area and then raises `ack`. It shares the single data-memory port with the core through a bus_req/bus_gnt handshake.

## Interface
- SRC_BASE, 0: byte address of message 0 low byte.
- DST_BASE, 30: byte address of codeword 0 low byte.
- NUM_MSG, 15: number of messages, 1..127.
- AW, 8: memory address width.
- clock  in  1  single clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  1  start pulse, sampled only in IDLE or DONE.
- ack  out  1  job complete; level held.
- bus_req  out  1  request for the data-memory port.
- bus_gnt  in  1  port granted by the arbiter.
- mem_addr  out  AW  byte address.
- mem_rd  out  1  read strobe; mem_rdata is valid on the following cycle.
- mem_rdata  in  8  read data.
- mem_wr  out  1  write strobe; writes on the same edge.
- mem_wdata  out  8  write data.
- stall_cnt  out  16  grant-stall cycle count (see Configuration).

## Operation
- Message i layout:
  - Low byte at SRC_BASE+2i = d[8:1].
  - High byte at SRC_BASE+2i+1: bits [2:0] = d[11:9]; bits [7:3] ignored.
- Parity equations:
  - p8 = ^d[11:5]
  - p4 = ^d[11:8] ^ ^d[4:2]
  - p2 = d11^d10^d7^d6^d4^d3^d1
  - p1 = d11^d9^d7^d5^d4^d2^d1
  - p0 = ^d[11:1]^p8^p4^p2^p1
- Codeword = {d[11:5],p8,d[4:2],p4,d[1],p2,p1,p0}.
  - High byte written to DST_BASE+2i+1.
  - Low byte written to DST_BASE+2i.
- FSM states: IDLE, WAIT_GNT, RD_LO, RD_HI, ENC, WR_LO, WR_HI, DONE.
  - IDLE: req=1 goes to WAIT_GNT; clear message index; clear ack.
  - WAIT_GNT: bus_req=1; on bus_gnt=1 go to RD_LO.
  - RD_LO: mem_rd=1, addr = SRC_BASE+2i. Go to RD_HI.
  - RD_HI: capture low byte from mem_rdata; mem_rd=1, addr = SRC_BASE+2i+1. Go to ENC.
  - ENC: capture d[11:9] from mem_rdata[2:0]; register the codeword. Go to WR_LO.
  - WR_LO: mem_wr=1, addr = DST_BASE+2i, wdata = codeword[7:0]. Go to WR_HI.
  - WR_HI: mem_wr=1, addr = DST_BASE+2i+1, wdata = codeword[15:8]. If i==NUM_MSG-1 go to DONE, else i++ and go to RD_LO.
  - DONE: ack=1, bus_req=0. req=1 restarts via WAIT_GNT with ack cleared.
- bus_req stays high from WAIT_GNT through WR_HI of the last message.
- Grant loss in RD_LO..WR_HI:
  - FSM holds its state with mem_rd=mem_wr=0.
  - If the held state is RD_HI or ENC, it re-enters the preceding read state so the lost read is re-issued.
  - Captured bytes are retained across the stall.
- req asserted outside IDLE/DONE is ignored.
- Address arithmetic is modulo 2^AW.

## Timing
- Reset values: ack=0, bus_req=0, mem_rd=0, mem_wr=0, mem_addr=0, mem_wdata=0, stall_cnt=0; state=IDLE.
- Reset asserted mid-job aborts immediately: no further strobes, and partial writes are not undone.
- Outputs are registered from state; mem strobes are never asserted while bus_gnt=0.
- Latency with bus_gnt held high: ack rises 5*NUM_MSG+1 cycles after the edge that samples req (76 for NUM_MSG=15).
- Each message takes 5 cycles; each grant-stall cycle adds one cycle.
- A re-issued read adds 1 extra cycle after the grant returns.
- A req arriving in the same cycle the FSM enters DONE is not sampled.

## Configuration
- HSEQ_STALL_CNT_EN defined:
  - stall_cnt increments, saturating at 16'hFFFF, every cycle with bus_req=1 and bus_gnt=0.
  - Cleared on each accepted req.
- HSEQ_STALL_CNT_EN undefined: stall_cnt is tied to 0 and no counter logic is built.

## Test plan
- Input low byte 8'h00, high byte 8'h00 (d=11'h000) -> codeword 16'h0000 at DST.
- d=11'h001 (low byte 8'h01, high byte 8'h00) -> written bytes 8'h0F at DST_BASE and 8'h00 at DST_BASE+1.
- d=11'h7FF (8'hFF, 8'h07), plus high-byte bits [7:3] set (high byte 8'hFF) -> 16'hFFFF; garbage bits ignored.
- 15 random messages, bus_gnt tied 1 -> all 15 codewords match the parity equations; ack rises exactly 76 cycles after req.
- bus_gnt dropped for 3 cycles during RD_HI of message 4 -> no strobes while gnt=0, read re-issued, all outputs correct; ack at cycle 80; stall_cnt=3 with HSEQ_STALL_CNT_EN.
- reset_n pulsed low during message 7 -> all outputs return to reset values at once; a following req completes the full job correctly.

Source files
------------

// File: rtl/hamming_enc_sequencer.sv
// hamming_enc_sequencer: reads NUM_MSG packed 11-bit messages from the shared
// data memory, Hamming(16,11)-encodes them with overall parity and writes the
// 16-bit codewords back, sharing the memory port via bus_req/bus_gnt.
// Optional build macro: HSEQ_STALL_CNT_EN enables the grant-stall counter.
module hamming_enc_sequencer #(
  parameter int unsigned SRC_BASE = 0,
  parameter int unsigned DST_BASE = 30,
  parameter int unsigned NUM_MSG  = 15,
  parameter int unsigned AW       = 8
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          req,
  output logic          ack,
  output logic          bus_req,
  input  logic          bus_gnt,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd,
  input  logic [7:0]    mem_rdata,
  output logic          mem_wr,
  output logic [7:0]    mem_wdata,
  output logic [15:0]   stall_cnt
);

  typedef enum logic [2:0] {
    IDLE, WAIT_GNT, RD_LO, RD_HI, ENC, WR_LO, WR_HI, DONE
  } state_t;

  localparam logic [6:0] LAST_IDX = 7'(NUM_MSG - 1);

  state_t        state, state_n;
  logic [6:0]    idx, idx_n;
  logic          rd_q, wr_q;
  logic          lo_tag;
  logic [7:0]    lo_q;
  logic [15:0]   cw_q, cw_calc, cw_src;
  logic [AW-1:0] src_lo, dst_lo, addr_n;
  logic [7:0]    wdata_n;
  logic          unused_hi_bits;

  assign unused_hi_bits = ^mem_rdata[7:3];

  function automatic logic [15:0] encode(input logic [11:1] d);
    logic p8, p4, p2, p1, p0;
    p8 = ^d[11:5];
    p4 = (^d[11:8]) ^ (^d[4:2]);
    p2 = d[11] ^ d[10] ^ d[7] ^ d[6] ^ d[4] ^ d[3] ^ d[1];
    p1 = d[11] ^ d[9] ^ d[7] ^ d[5] ^ d[4] ^ d[2] ^ d[1];
    p0 = (^d) ^ p8 ^ p4 ^ p2 ^ p1;
    return {d[11:5], p8, d[4:2], p4, d[1], p2, p1, p0};
  endfunction

  // Strobes are registered but gated by the live grant so none leaks out
  // in the first cycle of a grant loss.
  assign mem_rd = rd_q & bus_gnt;
  assign mem_wr = wr_q & bus_gnt;

  // Next state and message index.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    case (state)
      IDLE, DONE: begin
        if (req) begin
          state_n = WAIT_GNT;
          idx_n   = '0;
        end
      end
      WAIT_GNT: if (bus_gnt) state_n = RD_LO;
      RD_LO:    if (bus_gnt) state_n = RD_HI;
      // Grant loss here means the read just issued was lost: step back.
      RD_HI:    state_n = bus_gnt ? ENC : RD_LO;
      ENC:      state_n = bus_gnt ? WR_LO : RD_HI;
      WR_LO:    if (bus_gnt) state_n = WR_HI;
      WR_HI: begin
        if (bus_gnt) begin
          if (idx == LAST_IDX) begin
            state_n = DONE;
          end else begin
            state_n = RD_LO;
            idx_n   = idx + 7'd1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Address and write-data decode for the upcoming state.
  always_comb begin
    src_lo  = AW'(SRC_BASE) + AW'({idx_n, 1'b0});
    dst_lo  = AW'(DST_BASE) + AW'({idx_n, 1'b0});
    cw_calc = encode({mem_rdata[2:0], lo_q});
    // Entering WR_LO from ENC the codeword register is loaded on that same
    // edge, so the low write byte must come from the freshly computed value.
    cw_src  = (state == ENC) ? cw_calc : cw_q;
    addr_n  = '0;
    wdata_n = '0;
    case (state_n)
      RD_LO: addr_n = src_lo;
      RD_HI: addr_n = src_lo + AW'(1);
      WR_LO: begin
        addr_n  = dst_lo;
        wdata_n = cw_src[7:0];
      end
      WR_HI: begin
        addr_n  = dst_lo + AW'(1);
        wdata_n = cw_q[15:8];
      end
      default: ;
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      idx       <= '0;
      ack       <= 1'b0;
      bus_req   <= 1'b0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      lo_tag    <= 1'b0;
      lo_q      <= '0;
      cw_q      <= '0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      ack       <= (state_n == DONE);
      bus_req   <= (state_n != IDLE) && (state_n != DONE);
      rd_q      <= (state_n == RD_LO) || (state_n == RD_HI);
      wr_q      <= (state_n == WR_LO) || (state_n == WR_HI);
      mem_addr  <= addr_n;
      mem_wdata <= wdata_n;
      // Capture follows the read that actually went out, not the state,
      // so a stall never latches stale read data.
      lo_tag    <= (state == RD_LO) && bus_gnt;
      if (lo_tag) lo_q <= mem_rdata;
      if (state == ENC && bus_gnt) cw_q <= cw_calc;
    end
  end

`ifdef HSEQ_STALL_CNT_EN
  logic accept;
  assign accept = ((state == IDLE) || (state == DONE)) && req;

  // Saturating count of cycles spent requesting without a grant.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= '0;
    end else if (accept) begin
      stall_cnt <= '0;
    end else if (bus_req && !bus_gnt && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hamming_enc_sequencer.sv
// tb_hamming_enc_sequencer: table vectors, random jobs, grant stall and
// mid-job reset against a position-based Hamming reference model.
module tb_hamming_enc_sequencer;
  localparam int SRC  = 0;
  localparam int DST  = 30;
  localparam int NMSG = 15;
`ifdef HSEQ_STALL_CNT_EN
  localparam logic [15:0] STALL_EXP = 16'd3;
`else
  localparam logic [15:0] STALL_EXP = 16'd0;
`endif

  logic        clock = 1'b0;
  logic        reset_n, req, ack, bus_req, bus_gnt, mem_rd, mem_wr;
  logic [7:0]  mem_addr, mem_rdata, mem_wdata;
  logic [15:0] stall_cnt;

  logic [7:0]  mem [256];
  logic        bd_we;
  logic [7:0]  bd_addr, bd_data;
  logic [7:0]  src_lo [NMSG];
  logic [7:0]  src_hi [NMSG];

  int checks = 0, errors = 0;
  int strobe_viol = 0, rd_cnt = 0, wr_cnt = 0;

  typedef struct {
    logic [7:0]  lo;
    logic [7:0]  hi;
    logic [15:0] cw;
  } vec_t;
  vec_t tbl [4];

  hamming_enc_sequencer #(.SRC_BASE(SRC), .DST_BASE(DST), .NUM_MSG(NMSG), .AW(8)) dut (
    .clock(clock), .reset_n(reset_n), .req(req), .ack(ack),
    .bus_req(bus_req), .bus_gnt(bus_gnt), .mem_addr(mem_addr),
    .mem_rd(mem_rd), .mem_rdata(mem_rdata), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .stall_cnt(stall_cnt)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (mem_wr) mem[mem_addr] <= mem_wdata;
    if (mem_rd) mem_rdata <= mem[mem_addr];
  end

  always @(negedge clock) begin
    if (reset_n) begin
      if ((mem_rd || mem_wr) && !bus_gnt) strobe_viol <= strobe_viol + 1;
      if (mem_rd) rd_cnt <= rd_cnt + 1;
      if (mem_wr) wr_cnt <= wr_cnt + 1;
    end
  end

  // Standard Hamming placement: data fills non-power-of-two positions 1..15,
  // parity bit at position p covers every position with bit p set, bit 0 is
  // overall parity.
  function automatic logic [15:0] ref_cw(input logic [7:0] lo, input logic [7:0] hi);
    logic [10:0] data;
    logic [15:0] cw;
    logic        par;
    int          k;
    data = {hi[2:0], lo};
    cw   = '0;
    k    = 0;
    for (int pos = 1; pos < 16; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        cw[pos] = data[k];
        k++;
      end
    end
    for (int p = 1; p < 16; p = p * 2) begin
      par = 1'b0;
      for (int pos = 1; pos < 16; pos++) if ((pos & p) != 0) par ^= cw[pos];
      cw[p] = par;
    end
    cw[0] = ^cw[15:1];
    return cw;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic poke(input int a, input logic [7:0] d);
    bd_addr = 8'(a);
    bd_data = d;
    bd_we   = 1'b1;
    @(posedge clock);
    #1 bd_we = 1'b0;
  endtask

  task automatic load_job(input bit use_tbl);
    for (int i = 0; i < NMSG; i++) begin
      if (use_tbl && i < 4) begin
        src_lo[i] = tbl[i].lo;
        src_hi[i] = tbl[i].hi;
      end else begin
        src_lo[i] = 8'($urandom);
        src_hi[i] = 8'($urandom);
      end
      poke(SRC + 2 * i, src_lo[i]);
      poke(SRC + 2 * i + 1, src_hi[i]);
    end
    for (int a = DST; a < DST + 2 * NMSG; a++) poke(a, 8'hAA);
  endtask

  task automatic verify_all(input string tag);
    logic [15:0] e;
    for (int i = 0; i < NMSG; i++) begin
      e = ref_cw(src_lo[i], src_hi[i]);
      check($sformatf("%s_cw%0d_lo", tag, i), 32'(mem[DST + 2 * i]), 32'(e[7:0]));
      check($sformatf("%s_cw%0d_hi", tag, i), 32'(mem[DST + 2 * i + 1]), 32'(e[15:8]));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ack"}, 32'(ack), 0);
    check({tag, "_bus_req"}, 32'(bus_req), 0);
    check({tag, "_mem_rd"}, 32'(mem_rd), 0);
    check({tag, "_mem_wr"}, 32'(mem_wr), 0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 0);
    check({tag, "_mem_wdata"}, 32'(mem_wdata), 0);
    check({tag, "_stall_cnt"}, 32'(stall_cnt), 0);
  endtask

  // Pulses req, then counts edges until ack. g1/g2: cycles to re-pulse req,
  // drop_at/drop_len: grant gap, abort_at: return early (lat = -2).
  task automatic run_job(input int g1, input int g2, input int drop_at, input int drop_len,
                         input int abort_at, output int lat);
    int n;
    lat = -1;
    @(negedge clock);
    req = 1'b1;
    @(posedge clock);
    #1 req = 1'b0;
    check("ack_clear_on_req", 32'(ack), 0);
    n = 0;
    while (n < 300) begin
      @(posedge clock);
      n++;
      #1;
      req = (n == g1) || (n == g2);
      if (n == drop_at) bus_gnt = 1'b0;
      if (n == drop_at + drop_len) bus_gnt = 1'b1;
      if (n == abort_at) begin
        lat = -2;
        break;
      end
      if (ack) begin
        lat = n;
        break;
      end
    end
    req = 1'b0;
  endtask

  initial begin
    int lat, rd0, wr0;
    logic [15:0] e;

    tbl[0] = '{8'h00, 8'h00, 16'h0000};
    tbl[1] = '{8'h01, 8'h00, 16'h000F};
    tbl[2] = '{8'hFF, 8'hFF, 16'hFFFF};
    tbl[3] = '{8'hFF, 8'h07, 16'hFFFF};

    reset_n = 1'b1;
    req     = 1'b0;
    bus_gnt = 1'b1;
    bd_we   = 1'b0;
    bd_addr = '0;
    bd_data = '0;
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1 check_reset_outputs("rst");
    @(negedge clock) reset_n = 1'b1;

    // Job A: directed table vectors in messages 0..3.
    load_job(1'b1);
    run_job(1000, 1000, 1000, 0, 1000, lat);
    check("jobA_latency", 32'(lat), 76);
    for (int i = 0; i < 4; i++)
      check($sformatf("tbl%0d_cw", i), 32'({mem[DST + 2 * i + 1], mem[DST + 2 * i]}), 32'(tbl[i].cw));
    verify_all("jobA");
    check("jobA_stall", 32'(stall_cnt), 0);
    repeat (3) @(posedge clock);
    #1 check("jobA_ack_held", 32'(ack), 1);

    // Job B: req pulses while busy and on the edge entering DONE are ignored.
    load_job(1'b0);
    run_job(10, 75, 1000, 0, 1000, lat);
    check("jobB_latency", 32'(lat), 76);
    verify_all("jobB");
    repeat (2) @(posedge clock);
    #1;
    check("jobB_ack_no_restart", 32'(ack), 1);
    check("jobB_bus_req_low", 32'(bus_req), 0);

    // Job C: grant lost for 3 cycles during RD_HI of message 4.
    load_job(1'b0);
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    run_job(1000, 1000, 22, 3, 1000, lat);
    check("jobC_latency", 32'(lat), 80);
    verify_all("jobC");
    check("jobC_stall", 32'(stall_cnt), 32'(STALL_EXP));
    check("jobC_reads", 32'(rd_cnt - rd0), 31);
    check("jobC_writes", 32'(wr_cnt - wr0), 30);

    // Job D: reset during message 7, then Job E completes cleanly.
    load_job(1'b0);
    wr0 = wr_cnt;
    run_job(1000, 1000, 1000, 0, 37, lat);
    #2 reset_n = 1'b0;
    #1 check_reset_outputs("abort");
    @(posedge clock);
    #1 check_reset_outputs("abort_edge");
    e = ref_cw(src_lo[6], src_hi[6]);
    check("abort_msg6_kept", 32'(mem[DST + 13]), 32'(e[15:8]));
    check("abort_msg7_unwritten", 32'(mem[DST + 14]), 32'h0AA);
    check("abort_writes", 32'(wr_cnt - wr0), 14);
    @(negedge clock) reset_n = 1'b1;

    load_job(1'b0);
    run_job(1000, 1000, 1000, 0, 1000, lat);
    check("jobE_latency", 32'(lat), 76);
    verify_all("jobE");
    check("jobE_stall", 32'(stall_cnt), 0);

    @(negedge clock);
    check("strobe_without_gnt", 32'(strobe_viol), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
